clock_calendar_core: RTL and testbench

CLOCK_CALENDAR_CORE -- requirements
Module: clock_calendar_core

---
 rtl/clock_calendar_core.sv | 220 ++++++++++++++++++++++
 tb/tb_clock_calendar_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_calendar_core.sv
// rtl/clock_calendar_core.sv - BCD time-of-day and calendar counter with button-driven adjust mode
//
// Optional feature macro: LEAP_YEAR_EN. When defined, February has 29 days in Gregorian
// leap years. When undefined, February is always 28 days long.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous active-high reset
//   btn_mode   pulse, toggles adjust mode (dem_chinh)
//   btn_sel    pulse, advances the selected field while adjusting
//   btn_inc    pulse, increments the selected field while adjusting (no carry)
//   smh_dmy    0 = time group HH/MM/SS, 1 = date group DD/MO/YYYY is adjusted
//   bcd_ss/mm/hh/dd/mo   two-digit packed BCD outputs
//   bcd_yyyy   four-digit packed BCD year
//   dem_chinh  1 while adjust mode is active
//   blink_led  selected field: 00 none, 01 HH/DD, 10 MM/MO, 11 SS/YYYY

module clock_calendar_core #(
    parameter int CLK_HZ = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        smh_dmy,
    output logic [7:0]  bcd_ss,
    output logic [7:0]  bcd_mm,
    output logic [7:0]  bcd_hh,
    output logic [7:0]  bcd_dd,
    output logic [7:0]  bcd_mo,
    output logic [15:0] bcd_yyyy,
    output logic        dem_chinh,
    output logic [1:0]  blink_led
);

    localparam int              PS_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        SEL_NONE   = 2'b00,
        SEL_FIRST  = 2'b01,
        SEL_SECOND = 2'b10,
        SEL_THIRD  = 2'b11
    } sel_e;

    sel_e            sel_q;
    logic            dem_chinh_q;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [7:0]      ss_q, ss_d, mm_q, mm_d, hh_q, hh_d;
    logic [7:0]      dd_q, dd_d, mo_q, mo_d;
    logic [15:0]     yyyy_q, yyyy_d;
    logic            tick;
    logic            leap_cur, leap_new;
    logic [7:0]      mlen_cur, mlen_new;

    // Increment a two-digit BCD value, wrapping to 'first' once 'last' is reached.
    function automatic logic [7:0] bcd2_next(input logic [7:0] v, input logic [7:0] last,
                                             input logic [7:0] first);
        if (v >= last)
            return first;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Four-digit BCD increment; 9999 naturally rolls to 0000.
    function automatic logic [15:0] bcd4_next(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

`ifdef LEAP_YEAR_EN
    // Two BCD digits divisible by 4: even tens need units 0/4/8, odd tens need 2/6.
    function automatic logic bcd_div4(input logic [7:0] b);
        if (b[4])
            return (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
        return (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
    endfunction

    // Century years are leap only when the century digits are divisible by 4.
    function automatic logic is_leap(input logic [15:0] y);
        if (y[7:0] == 8'h00)
            return bcd_div4(y[15:8]);
        return bcd_div4(y[7:0]);
    endfunction
`endif

    function automatic logic [7:0] month_len(input logic [7:0] mo, input logic leap);
        case (mo)
            8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
            8'h02:                      return leap ? 8'h29 : 8'h28;
            default:                    return 8'h31;
        endcase
    endfunction

    always_comb begin
        ss_d   = ss_q;
        mm_d   = mm_q;
        hh_d   = hh_q;
        dd_d   = dd_q;
        mo_d   = mo_q;
        yyyy_d = yyyy_q;

`ifdef LEAP_YEAR_EN
        leap_cur = is_leap(yyyy_q);
`else
        leap_cur = 1'b0;
`endif
        mlen_cur = month_len(mo_q, leap_cur);

        // Prescaler is frozen at zero in adjust mode and restarts from zero on every mode toggle.
        tick = (ps_q == PS_LAST) && !dem_chinh_q;
        if (dem_chinh_q || btn_mode || (ps_q == PS_LAST))
            ps_d = '0;
        else
            ps_d = ps_q + PS_W'(1);

        if (tick) begin
            ss_d = bcd2_next(ss_q, 8'h59, 8'h00);
            if (ss_q >= 8'h59) begin
                mm_d = bcd2_next(mm_q, 8'h59, 8'h00);
                if (mm_q >= 8'h59) begin
                    hh_d = bcd2_next(hh_q, 8'h23, 8'h00);
                    if (hh_q >= 8'h23) begin
                        dd_d = bcd2_next(dd_q, mlen_cur, 8'h01);
                        if (dd_q >= mlen_cur) begin
                            mo_d = bcd2_next(mo_q, 8'h12, 8'h01);
                            if (mo_q >= 8'h12)
                                yyyy_d = bcd4_next(yyyy_q);
                        end
                    end
                end
            end
        end

        // Manual increments wrap within their own field; btn_mode suppresses them.
        if (dem_chinh_q && btn_inc && !btn_mode) begin
            case ({smh_dmy, sel_q})
                {1'b0, SEL_FIRST}:  hh_d   = bcd2_next(hh_q, 8'h23, 8'h00);
                {1'b0, SEL_SECOND}: mm_d   = bcd2_next(mm_q, 8'h59, 8'h00);
                {1'b0, SEL_THIRD}:  ss_d   = bcd2_next(ss_q, 8'h59, 8'h00);
                {1'b1, SEL_FIRST}:  dd_d   = bcd2_next(dd_q, mlen_cur, 8'h01);
                {1'b1, SEL_SECOND}: mo_d   = bcd2_next(mo_q, 8'h12, 8'h01);
                {1'b1, SEL_THIRD}:  yyyy_d = bcd4_next(yyyy_q);
                default: ;
            endcase
        end

        // A new month or year may be shorter than the current day; pull the day back in range.
`ifdef LEAP_YEAR_EN
        leap_new = is_leap(yyyy_d);
`else
        leap_new = 1'b0;
`endif
        mlen_new = month_len(mo_d, leap_new);
        if (dd_d > mlen_new)
            dd_d = mlen_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q   <= '0;
            ss_q   <= 8'h00;
            mm_q   <= 8'h00;
            hh_q   <= 8'h00;
            dd_q   <= 8'h01;
            mo_q   <= 8'h01;
            yyyy_q <= 16'h2000;
        end else begin
            ps_q   <= ps_d;
            ss_q   <= ss_d;
            mm_q   <= mm_d;
            hh_q   <= hh_d;
            dd_q   <= dd_d;
            mo_q   <= mo_d;
            yyyy_q <= yyyy_d;
        end
    end

    // Mode/selection state machine; btn_mode has priority over btn_sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            dem_chinh_q <= 1'b0;
            sel_q       <= SEL_NONE;
        end else if (btn_mode) begin
            dem_chinh_q <= !dem_chinh_q;
            sel_q       <= dem_chinh_q ? SEL_NONE : SEL_FIRST;
        end else if (dem_chinh_q && btn_sel) begin
            case (sel_q)
                SEL_FIRST:  sel_q <= SEL_SECOND;
                SEL_SECOND: sel_q <= SEL_THIRD;
                default:    sel_q <= SEL_FIRST;
            endcase
        end
    end

    assign bcd_ss    = ss_q;
    assign bcd_mm    = mm_q;
    assign bcd_hh    = hh_q;
    assign bcd_dd    = dd_q;
    assign bcd_mo    = mo_q;
    assign bcd_yyyy  = yyyy_q;
    assign dem_chinh = dem_chinh_q;
    assign blink_led = sel_q;

endmodule

// File: tb/tb_clock_calendar_core.sv
// tb/tb_clock_calendar_core.sv - self-checking bench for clock_calendar_core

module tb_clock_calendar_core;

    localparam int CLK_HZ = 4;
`ifdef LEAP_YEAR_EN
    localparam bit LEAP_ON = 1'b1;
`else
    localparam bit LEAP_ON = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        btn_mode = 1'b0;
    logic        btn_sel  = 1'b0;
    logic        btn_inc  = 1'b0;
    logic        smh_dmy  = 1'b0;
    logic [7:0]  bcd_ss, bcd_mm, bcd_hh, bcd_dd, bcd_mo;
    logic [15:0] bcd_yyyy;
    logic        dem_chinh;
    logic [1:0]  blink_led;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: plain integers for each field.
    int m_ss = 0, m_mm = 0, m_hh = 0, m_dd = 1, m_mo = 1, m_yr = 2000;
    int m_ps = 0, m_sel = 0;
    bit m_adj = 1'b0;

    clock_calendar_core #(.CLK_HZ(CLK_HZ)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc), .smh_dmy(smh_dmy),
        .bcd_ss(bcd_ss), .bcd_mm(bcd_mm), .bcd_hh(bcd_hh), .bcd_dd(bcd_dd), .bcd_mo(bcd_mo),
        .bcd_yyyy(bcd_yyyy), .dem_chinh(dem_chinh), .blink_led(blink_led)
    );

    always #5 clk = ~clk;

    function automatic bit leap(input int y);
        return LEAP_ON && (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0));
    endfunction

    function automatic int mlen(input int mo, input int y);
        if (mo == 2) return leap(y) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic logic [15:0] bcd4(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic advance_second();
        m_ss++;
        if (m_ss == 60) begin
            m_ss = 0; m_mm++;
            if (m_mm == 60) begin
                m_mm = 0; m_hh++;
                if (m_hh == 24) begin
                    m_hh = 0; m_dd++;
                    if (m_dd > mlen(m_mo, m_yr)) begin
                        m_dd = 1; m_mo++;
                        if (m_mo == 13) begin
                            m_mo = 1; m_yr = (m_yr + 1) % 10000;
                        end
                    end
                end
            end
        end
    endtask

    task automatic adjust_field(input int f);
        case (f)
            1: m_hh = (m_hh + 1) % 24;
            2: m_mm = (m_mm + 1) % 60;
            3: m_ss = (m_ss + 1) % 60;
            4: m_dd = (m_dd % mlen(m_mo, m_yr)) + 1;
            5: m_mo = (m_mo % 12) + 1;
            6: m_yr = (m_yr + 1) % 10000;
            default: ;
        endcase
        if (m_dd > mlen(m_mo, m_yr)) m_dd = mlen(m_mo, m_yr);
    endtask

    task automatic model_step();
        bit tk;
        if (rst) begin
            m_ss = 0; m_mm = 0; m_hh = 0; m_dd = 1; m_mo = 1; m_yr = 2000;
            m_ps = 0; m_sel = 0; m_adj = 1'b0;
        end else begin
            tk = (m_ps == CLK_HZ - 1) && !m_adj;
            m_ps = (m_adj || btn_mode) ? 0 : (m_ps + 1) % CLK_HZ;
            if (tk) advance_second();
            if (m_adj && btn_inc && !btn_mode) adjust_field(smh_dmy ? m_sel + 3 : m_sel);
            if (btn_mode) begin
                m_adj = !m_adj;
                m_sel = m_adj ? 1 : 0;
            end else if (m_adj && btn_sel) begin
                m_sel = (m_sel % 3) + 1;
            end
        end
    endtask

    always begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always begin
        @(negedge clk);
        if (chk_en) begin
            logic [58:0] got_v, exp_v;
            got_v = {bcd_yyyy, bcd_mo, bcd_dd, bcd_hh, bcd_mm, bcd_ss, dem_chinh, blink_led};
            exp_v = {bcd4(m_yr), bcd2(m_mo), bcd2(m_dd), bcd2(m_hh), bcd2(m_mm), bcd2(m_ss),
                     m_adj, 2'(m_sel)};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL model_compare t=%0t got=%h expected=%h", $time, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic pulse(input bit m, input bit s, input bit i);
        btn_mode = m; btn_sel = s; btn_inc = i;
        @(posedge clk); #2;
        btn_mode = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic incs(input int n);
        repeat (n) pulse(1'b0, 1'b0, 1'b1);
    endtask

    task automatic goto_sel(input int t);
        for (int k = 0; k < 3 && m_sel != t; k++) pulse(1'b0, 1'b1, 1'b0);
    endtask

    // Enter adjust mode and dial in a full date/time; leaves selection on SS with smh_dmy=0.
    task automatic set_dt(input int y, input int mo, input int d, input int h, input int mi,
                          input int s);
        if (!m_adj) pulse(1'b1, 1'b0, 1'b0);
        smh_dmy = 1'b1;
        goto_sel(3); incs((y - m_yr + 10000) % 10000);
        goto_sel(2); incs((mo - m_mo + 12) % 12);
        goto_sel(1); incs((d - m_dd + mlen(m_mo, m_yr)) % mlen(m_mo, m_yr));
        smh_dmy = 1'b0;
        goto_sel(1); incs((h - m_hh + 24) % 24);
        goto_sel(2); incs((mi - m_mm + 60) % 60);
        goto_sel(3); incs((s - m_ss + 60) % 60);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ss"}, {8'h0, bcd_ss}, 16'h0000);
        chk({tag, "_mm"}, {8'h0, bcd_mm}, 16'h0000);
        chk({tag, "_hh"}, {8'h0, bcd_hh}, 16'h0000);
        chk({tag, "_dd"}, {8'h0, bcd_dd}, 16'h0001);
        chk({tag, "_mo"}, {8'h0, bcd_mo}, 16'h0001);
        chk({tag, "_yyyy"}, bcd_yyyy, 16'h2000);
        chk({tag, "_dem_chinh"}, {15'h0, dem_chinh}, 16'h0000);
        chk({tag, "_blink"}, {14'h0, blink_led}, 16'h0000);
    endtask

    task automatic feb28_rollover(input int y, input logic [7:0] exp_dd, input logic [7:0] exp_mo);
        set_dt(y, 2, 28, 23, 59, 59);
        pulse(1'b1, 1'b0, 1'b0);
        idle(CLK_HZ);
        chk($sformatf("feb_%0d_dd", y), {8'h0, bcd_dd}, {8'h0, exp_dd});
        chk($sformatf("feb_%0d_mo", y), {8'h0, bcd_mo}, {8'h0, exp_mo});
        chk($sformatf("feb_%0d_hh", y), {8'h0, bcd_hh}, 16'h0000);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_en = 1'b1;
        chk_reset_values("reset");

        // Select/increment outside adjust mode must do nothing.
        idle(3);
        pulse(1'b0, 1'b1, 1'b1);
        chk("idle_sel_blink", {14'h0, blink_led}, 16'h0000);
        chk("idle_sel_dem", {15'h0, dem_chinh}, 16'h0000);
        idle(6);

        // Full carry chain through the millennium.
        set_dt(2999, 12, 31, 23, 59, 59);
        chk("pre_hh", {8'h0, bcd_hh}, 16'h0023);
        chk("pre_yyyy", bcd_yyyy, 16'h2999);
        chk("pre_blink", {14'h0, blink_led}, 16'h0003);
        pulse(1'b1, 1'b0, 1'b0);
        chk("exit_dem", {15'h0, dem_chinh}, 16'h0000);
        chk("exit_blink", {14'h0, blink_led}, 16'h0000);
        idle(CLK_HZ - 1);
        chk("hold_ss", {8'h0, bcd_ss}, 16'h0059);
        idle(1);
        chk("roll_ss", {8'h0, bcd_ss}, 16'h0000);
        chk("roll_mm", {8'h0, bcd_mm}, 16'h0000);
        chk("roll_hh", {8'h0, bcd_hh}, 16'h0000);
        chk("roll_dd", {8'h0, bcd_dd}, 16'h0001);
        chk("roll_mo", {8'h0, bcd_mo}, 16'h0001);
        chk("roll_yyyy", bcd_yyyy, 16'h3000);

        // February end with and without leap-year support.
        feb28_rollover(2000, LEAP_ON ? 8'h29 : 8'h01, LEAP_ON ? 8'h02 : 8'h03);
        feb28_rollover(2024, LEAP_ON ? 8'h29 : 8'h01, LEAP_ON ? 8'h02 : 8'h03);
        feb28_rollover(2100, 8'h01, 8'h03);

        // Seconds wrap under manual increment without carry, and no counting while adjusting.
        set_dt(2100, 3, 1, 10, 20, 59);
        chk("adj_blink_ss", {14'h0, blink_led}, 16'h0003);
        incs(1);
        chk("adj_ss_wrap", {8'h0, bcd_ss}, 16'h0000);
        chk("adj_mm_kept", {8'h0, bcd_mm}, 16'h0020);
        idle(3 * CLK_HZ);
        chk("adj_frozen_ss", {8'h0, bcd_ss}, 16'h0000);
        chk("adj_frozen_dem", {15'h0, dem_chinh}, 16'h0001);

        // Select and increment together: increment first, then advance the selection.
        goto_sel(1);
        pulse(1'b0, 1'b1, 1'b1);
        chk("selinc_hh", {8'h0, bcd_hh}, 16'h0011);
        chk("selinc_blink", {14'h0, blink_led}, 16'h0002);

        // Month change clamps the day; mode beats increment.
        set_dt(2023, 1, 31, 8, 0, 0);
        smh_dmy = 1'b1;
        goto_sel(2);
        incs(1);
        chk("clamp_mo", {8'h0, bcd_mo}, 16'h0002);
        chk("clamp_dd", {8'h0, bcd_dd}, 16'h0028);
        pulse(1'b1, 1'b0, 1'b1);
        chk("mode_inc_dem", {15'h0, dem_chinh}, 16'h0000);
        chk("mode_inc_blink", {14'h0, blink_led}, 16'h0000);
        chk("mode_inc_mo", {8'h0, bcd_mo}, 16'h0002);

        // Day wraps at month length with no carry into the month.
        set_dt(2023, 4, 30, 0, 0, 0);
        smh_dmy = 1'b1;
        goto_sel(1);
        incs(1);
        chk("dd_wrap_dd", {8'h0, bcd_dd}, 16'h0001);
        chk("dd_wrap_mo", {8'h0, bcd_mo}, 16'h0004);

        // Reset in the middle of an adjust session.
        set_dt(2023, 4, 1, 12, 34, 56);
        chk("mid_adj_ss", {8'h0, bcd_ss}, 16'h0056);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk_reset_values("mid_rst");
        idle(2 * CLK_HZ + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
